// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the sequential a + b*c datapath.
package fp_mac_pkg;
  localparam int DW      = 64;
  localparam int MUL_LAT = 3;  // DoubleMultiply: cycles from reset release to data_ready
  localparam int ADD_LAT = 3;  // DoubleAdder: same measure

  typedef enum logic [2:0] {IDLE, MULT, ADD, NEXT, DONE} fp_mac_state_t;

  localparam logic [DW-1:0] FP_ZERO  = 64'h0000000000000000;
  localparam logic [DW-1:0] FP_HALF  = 64'h3FE0000000000000;
  localparam logic [DW-1:0] FP_ONE   = 64'h3FF0000000000000;
  localparam logic [DW-1:0] FP_TWO   = 64'h4000000000000000;
  localparam logic [DW-1:0] FP_THREE = 64'h4008000000000000;
  localparam logic [DW-1:0] FP_SEVEN = 64'h401C000000000000;
  localparam logic [DW-1:0] FP_QNAN  = 64'h7FF8000000000000;
endpackage

// File: rtl/fp_double_cores.sv
// Multi-cycle IEEE-754 double multiplier and adder. Both cores start
// counting when their reset is released and present the result with a
// data_ready level LAT cycles later. Round-to-nearest-even; subnormal
// inputs and outputs are flushed to signed zero.
module DoubleMultiply
  import fp_mac_pkg::*;
#(
  parameter int LAT = MUL_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] dataa,
  input  logic [DW-1:0] datab,
  output logic [DW-1:0] result,
  output logic          data_ready
);
  logic [7:0] cnt;

  function automatic logic [63:0] fmul(input logic [63:0] x, input logic [63:0] y);
    logic              s, g, st, xnan, ynan, xinf, yinf, xz, yz;
    logic [52:0]       m;
    logic [105:0]      p;
    logic [53:0]       mr;
    logic signed [13:0] e;
    logic [63:0]       r;
    s    = x[63] ^ y[63];
    xnan = (&x[62:52]) & (|x[51:0]);
    ynan = (&y[62:52]) & (|y[51:0]);
    xinf = (&x[62:52]) & ~(|x[51:0]);
    yinf = (&y[62:52]) & ~(|y[51:0]);
    xz   = (x[62:52] == 11'd0);
    yz   = (y[62:52] == 11'd0);
    p    = 106'({1'b1, x[51:0]}) * 106'({1'b1, y[51:0]});
    e    = $signed({3'b000, x[62:52]}) + $signed({3'b000, y[62:52]}) - 14'sd1023;
    if (p[105]) begin
      m = p[105:53]; g = p[52]; st = |p[51:0]; e = e + 14'sd1;
    end else begin
      m = p[104:52]; g = p[51]; st = |p[50:0];
    end
    mr = {1'b0, m} + {53'd0, g & (st | m[0])};
    if (mr[53]) begin
      mr = mr >> 1;
      e  = e + 14'sd1;
    end
    if (xnan || ynan || (xinf && yz) || (yinf && xz)) r = FP_QNAN;
    else if (xinf || yinf)                            r = {s, 11'h7FF, 52'd0};
    else if (xz || yz)                                r = {s, 63'd0};
    else if (e >= 14'sd2047)                          r = {s, 11'h7FF, 52'd0};
    else if (e <= 14'sd0)                             r = {s, 63'd0};
    else                                              r = {s, e[10:0], mr[51:0]};
    return r;
  endfunction

  // Latency counter; result is captured once, on the last counting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 8'd0;
      data_ready <= 1'b0;
      result     <= '0;
    end else begin
      if (cnt != 8'(LAT)) cnt <= cnt + 8'd1;
      if (cnt == 8'(LAT - 1)) begin
        data_ready <= 1'b1;
        result     <= fmul(dataa, datab);
      end
    end
  end
endmodule

module DoubleAdder
  import fp_mac_pkg::*;
#(
  parameter int LAT = ADD_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] dataa,
  input  logic [DW-1:0] datab,
  output logic [DW-1:0] result,
  output logic          data_ready
);
  logic [7:0] cnt;

  function automatic logic [63:0] fadd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0]        big, sml, r;
    logic               xnan, ynan, xinf, yinf, eff_sub, g, st, sz;
    logic [10:0]        d;
    logic [52:0]        mb, ms, m;
    logic [56:0]        xs, ys, ys0, s;
    logic [5:0]         lz;
    logic [53:0]        mr;
    logic signed [13:0] e;
    xnan = (&x[62:52]) & (|x[51:0]);
    ynan = (&y[62:52]) & (|y[51:0]);
    xinf = (&x[62:52]) & ~(|x[51:0]);
    yinf = (&y[62:52]) & ~(|y[51:0]);
    // Larger magnitude first so the alignment shift is always rightwards.
    if (x[62:0] >= y[62:0]) begin big = x; sml = y; end
    else begin big = y; sml = x; end
    mb  = (big[62:52] == 11'd0) ? 53'd0 : {1'b1, big[51:0]};
    ms  = (sml[62:52] == 11'd0) ? 53'd0 : {1'b1, sml[51:0]};
    d   = big[62:52] - sml[62:52];
    xs  = {1'b0, mb, 3'b000};
    ys0 = {1'b0, ms, 3'b000};
    if (d > 11'd56) begin
      ys    = 57'd0;
      ys[0] = |ms;
    end else begin
      ys    = ys0 >> d;
      ys[0] = ys[0] | (|(ys0 & ((57'd1 << d) - 57'd1)));
    end
    eff_sub = big[63] ^ sml[63];
    s  = eff_sub ? (xs - ys) : (xs + ys);
    sz = (s == 57'd0);
    e  = $signed({3'b000, big[62:52]});
    lz = 6'd0;
    if (s[56]) begin
      s = {1'b0, s[56:2], s[1] | s[0]};
      e = e + 14'sd1;
    end else begin
      for (int i = 0; i < 56; i++) if (s[i]) lz = 6'(55 - i);
      s = s << lz;
      e = e - $signed({8'd0, lz});
    end
    m  = s[55:3];
    g  = s[2];
    st = s[1] | s[0];
    mr = {1'b0, m} + {53'd0, g & (st | m[0])};
    if (mr[53]) begin
      mr = mr >> 1;
      e  = e + 14'sd1;
    end
    if (xnan || ynan || (xinf && yinf && (x[63] != y[63]))) r = FP_QNAN;
    else if (xinf)                      r = x;
    else if (yinf)                      r = y;
    else if (mb == 53'd0)               r = {x[63] & y[63], 63'd0};
    else if (sz)                        r = 64'd0;  // exact cancellation gives +0
    else if (e >= 14'sd2047)            r = {big[63], 11'h7FF, 52'd0};
    else if (e <= 14'sd0)               r = {big[63], 63'd0};
    else                                r = {big[63], e[10:0], mr[51:0]};
    return r;
  endfunction

  // Latency counter; result is captured once, on the last counting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 8'd0;
      data_ready <= 1'b0;
      result     <= '0;
    end else begin
      if (cnt != 8'(LAT)) cnt <= cnt + 8'd1;
      if (cnt == 8'(LAT - 1)) begin
        data_ready <= 1'b1;
        result     <= fadd(dataa, datab);
      end
    end
  end
endmodule

// File: rtl/fp_mul_add_core.sv
// Shared arithmetic: one multiplier, one adder and the product register.
// Each core is held in reset whenever its enable is low, so every
// operation starts from a cleared core. With FP_MAC_SUB_EN defined the
// product sign is inverted at capture to form a - b*c.
module fp_mul_add_core
  import fp_mac_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          mul_en,
  input  logic          add_en,
`ifdef FP_MAC_SUB_EN
  input  logic          neg,
`endif
  input  logic [DW-1:0] mul_a,
  input  logic [DW-1:0] mul_b,
  input  logic [DW-1:0] addend,
  output logic          mul_done,
  output logic          add_done,
  output logic [DW-1:0] sum
);
  logic [DW-1:0] mul_res;
  logic [DW-1:0] prod_q;
  logic          mul_rst, add_rst;

  assign mul_rst = ~mul_en | reset;
  assign add_rst = ~add_en | reset;

  DoubleMultiply u_mul (
    .clk        (clk),
    .reset      (mul_rst),
    .dataa      (mul_a),
    .datab      (mul_b),
    .result     (mul_res),
    .data_ready (mul_done)
  );

  DoubleAdder u_add (
    .clk        (clk),
    .reset      (add_rst),
    .dataa      (prod_q),
    .datab      (addend),
    .result     (sum),
    .data_ready (add_done)
  );

  // Capture the product when the multiplier reports ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
    end else if (mul_en && mul_done) begin
`ifdef FP_MAC_SUB_EN
      prod_q <= {mul_res[DW-1] ^ neg, mul_res[DW-2:0]};
`else
      prod_q <= mul_res;
`endif
    end
  end
endmodule

// File: rtl/fp_mul_add_seq.sv
// y[i] = a[i] + b[i]*c[i] for CHANNELS double channels, evaluated one
// channel at a time through a shared multiplier and adder.
// Optional FP_MAC_SUB_EN adds the per-channel sub port (y = a - b*c).
module fp_mul_add_seq
  import fp_mac_pkg::*;
#(
  parameter int CHANNELS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CHANNELS*DW-1:0] a,
  input  logic [CHANNELS*DW-1:0] b,
  input  logic [CHANNELS*DW-1:0] c,
`ifdef FP_MAC_SUB_EN
  input  logic [CHANNELS-1:0]    sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   data_ready,
  output logic [CHANNELS*DW-1:0] result
);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);

  fp_mac_state_t state, state_n;
  logic [IDX_W-1:0]               idx;
  logic [CHANNELS-1:0][DW-1:0]    a_q, b_q, c_q, result_q;
`ifdef FP_MAC_SUB_EN
  logic [CHANNELS-1:0]            sub_q;
`endif
  logic          mul_en, add_en, mul_done, add_done;
  logic [DW-1:0] sum;

  assign result = result_q;

  fp_mul_add_core u_core (
    .clk      (clk),
    .reset    (reset),
    .mul_en   (mul_en),
    .add_en   (add_en),
`ifdef FP_MAC_SUB_EN
    .neg      (sub_q[idx]),
`endif
    .mul_a    (b_q[idx]),
    .mul_b    (c_q[idx]),
    .addend   (a_q[idx]),
    .mul_done (mul_done),
    .add_done (add_done),
    .sum      (sum)
  );

  // State, operand latches, channel index and result slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      data_ready <= 1'b0;
      result_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
`ifdef FP_MAC_SUB_EN
      sub_q      <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          a_q        <= a;
          b_q        <= b;
          c_q        <= c;
`ifdef FP_MAC_SUB_EN
          sub_q      <= sub;
`endif
          idx        <= '0;
          data_ready <= 1'b0;
        end
        ADD:  if (add_done) result_q[idx] <= sum;
        NEXT: if (idx != LAST) idx <= idx + 1'b1;
        DONE: data_ready <= 1'b1;
        default: ;
      endcase
    end
  end

  // Next state and decoded outputs; enables are pure state decodes so a
  // core is released exactly while its state is active.
  always_comb begin
    state_n = state;
    mul_en  = 1'b0;
    add_en  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = MULT;
      end
      MULT: begin
        mul_en = 1'b1;
        if (mul_done) state_n = ADD;
      end
      ADD: begin
        add_en = 1'b1;
        if (add_done) state_n = NEXT;
      end
      NEXT: state_n = (idx == LAST) ? DONE : MULT;
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_mul_add_seq.sv
`define CHK(tag, obs, exp) begin n_cmp++; assert ((obs) === (exp)) else begin n_bad++; $error("FAIL %s: got %h expected %h", tag, obs, exp); end end

module tb_fp_mul_add_seq;
  import fp_mac_pkg::*;

  localparam logic [63:0] FP_SIX  = 64'h4018000000000000;
  localparam logic [63:0] FP_FIVE = 64'h4014000000000000;
  localparam int LAT2 = 1 + 2 * (3 + 3 + 3);
  localparam int LAT1 = 1 + 1 * (3 + 3 + 3);

  logic         clk, reset;
  logic         start, start1;
  logic [127:0] a, b, c;
  logic [63:0]  a1, b1, c1;
  logic         busy, done, data_ready, busy1, done1, data_ready1;
  logic [127:0] result;
  logic [63:0]  result1;
`ifdef FP_MAC_SUB_EN
  logic [1:0]   sub;
  logic [0:0]   sub1;
`endif
  int n_cmp, n_bad, cyc, pulses;

  fp_mul_add_seq #(.CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c(c),
`ifdef FP_MAC_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .data_ready(data_ready), .result(result)
  );

  fp_mul_add_seq #(.CHANNELS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .c(c1),
`ifdef FP_MAC_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .data_ready(data_ready1), .result(result1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic accept2();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit one, output int n);
    n = 1;
    while (!(one ? done1 : done) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    n_cmp++;
    if (!(one ? done1 : done)) begin
      n_bad++;
      $error("FAIL wait_done: no done pulse within %0d cycles", n);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    a = '0; b = '0; c = '0; a1 = '0; b1 = '0; c1 = '0;
`ifdef FP_MAC_SUB_EN
    sub = 2'b00; sub1 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_dr", data_ready, 1'b0)
    `CHK("rst_result", result, 128'd0)
    `CHK("rst_busy1", busy1, 1'b0)
    `CHK("rst_result1", result1, 64'd0)
    n_cmp++;
    if (dut2.state !== IDLE) begin
      n_bad++;
      $error("FAIL rst_state: got %0d expected IDLE", dut2.state);
    end

    a = {FP_ONE, FP_ONE}; b = {FP_TWO, FP_TWO}; c = {FP_THREE, FP_HALF};
    accept2();
    a = {FP_SEVEN, FP_SEVEN}; b = '1; c = '1;
    `CHK("acc_busy", busy, 1'b1)
    `CHK("acc_dr", data_ready, 1'b0)
    wait_done(1'b0, cyc);
    `CHK("lat2", cyc, LAT2)
    `CHK("basic_ch0", result[63:0], FP_TWO)
    `CHK("basic_ch1", result[127:64], FP_SEVEN)
    @(posedge clk); #1;
    `CHK("post_done", done, 1'b0)
    `CHK("post_busy", busy, 1'b0)
    `CHK("post_dr", data_ready, 1'b1)

`ifdef FP_MAC_SUB_EN
    a = {FP_ONE, FP_ONE}; b = {FP_TWO, FP_TWO}; c = {FP_THREE, FP_HALF};
    sub = 2'b01;
    accept2();
    sub = 2'b00;
    wait_done(1'b0, cyc);
    `CHK("sub_ch0", result[63:0], FP_ZERO)
    `CHK("sub_ch1", result[127:64], FP_SEVEN)
    @(posedge clk); #1;
`endif

    a = {FP_TWO, FP_THREE}; b = {FP_HALF, FP_TWO}; c = {FP_TWO, FP_TWO};
    accept2();
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = {FP_ONE, FP_ONE}; b = {FP_ONE, FP_ONE}; c = {FP_ONE, FP_ONE};
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    `CHK("ign_pulses", pulses, 1)
    `CHK("ign_ch0", result[63:0], FP_SEVEN)
    `CHK("ign_ch1", result[127:64], FP_THREE)

    a = {FP_ONE, FP_ONE}; b = {FP_TWO, FP_TWO}; c = {FP_THREE, FP_HALF};
    accept2();
    repeat (14) @(posedge clk);
    #1;
    `CHK("mid_state", dut2.state, ADD)
    `CHK("mid_ch0", result[63:0], FP_TWO)
    `CHK("mid_ch1_hold", result[127:64], FP_THREE)
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    `CHK("mr_busy", busy, 1'b0)
    `CHK("mr_done", done, 1'b0)
    `CHK("mr_dr", data_ready, 1'b0)
    `CHK("mr_result", result, 128'd0)
    `CHK("mr_state", dut2.state, IDLE)
    accept2();
    wait_done(1'b0, cyc);
    `CHK("rerun_lat", cyc, LAT2)
    `CHK("rerun_ch0", result[63:0], FP_TWO)
    `CHK("rerun_ch1", result[127:64], FP_SEVEN)
    @(posedge clk); #1;

    a = {FP_ONE, FP_ONE}; b = {FP_TWO, FP_TWO}; c = {FP_THREE, FP_TWO};
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 a = {FP_SEVEN, FP_ZERO}; b = {FP_ONE, FP_THREE}; c = {FP_ZERO, FP_TWO};
    wait_done(1'b0, cyc);
    `CHK("b2b_lat1", cyc, LAT2)
    `CHK("b2b1_ch0", result[63:0], FP_FIVE)
    `CHK("b2b1_ch1", result[127:64], FP_SEVEN)
    @(posedge clk); #1;
    `CHK("b2b_idle_dr", data_ready, 1'b1)
    `CHK("b2b_idle_busy", busy, 1'b0)
    @(posedge clk); #1;
    start = 1'b0;
    `CHK("b2b_acc_dr", data_ready, 1'b0)
    `CHK("b2b_acc_busy", busy, 1'b1)
    wait_done(1'b0, cyc);
    `CHK("b2b_lat2", cyc, LAT2)
    `CHK("b2b2_ch0", result[63:0], FP_SIX)
    `CHK("b2b2_ch1", result[127:64], FP_SEVEN)
    @(posedge clk); #1;
    `CHK("b2b_end_dr", data_ready, 1'b1)

    a1 = FP_ONE; b1 = FP_TWO; c1 = FP_THREE;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    wait_done(1'b1, cyc);
    `CHK("ch1_lat", cyc, LAT1)
    `CHK("ch1_result", result1, FP_SEVEN)
    @(posedge clk); #1;
    `CHK("ch1_dr", data_ready1, 1'b1)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_mul_add_seq.md
# fp_mul_add_seq

Parametrised successor of the single-term `l1 + l2*cos` kernel block. It evaluates y[i] = a[i] + b[i]*c[i] for CHANNELS independent IEEE-754 double channels in one request. Each request shares one `DoubleMultiply` and one `DoubleAdder`, run in sequence. It sits in the inverse-kinematics datapath and lets one instance produce several K-style terms per control update.

## Interface
Parameters:
- CHANNELS, 2: number of channels per request, 1..16.
- IDX_W, $clog2(CHANNELS) (min 1): derived channel index width; not overridden.

Ports:
- clk  in  1  Single clock for the block.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  Request strobe; sampled only in IDLE.
- a  in  CHANNELS*64  Addends; channel i at [64*i+63:64*i].
- b  in  CHANNELS*64  Multiplicands, same packing.
- c  in  CHANNELS*64  Multipliers, same packing.
- sub  in  CHANNELS  Per-channel subtract select; present only with FP_MAC_SUB_EN.
- busy  out  1  High from the cycle after start is accepted until DONE ends.
- done  out  1  One-cycle pulse when all channels have completed.
- data_ready  out  1  Level output; set with done, cleared when the next start is accepted.
- result  out  CHANNELS*64  Per-channel results, same packing as a.

## Operation
- FSM states: IDLE, MULT, ADD, NEXT, DONE.
- IDLE:
  - start=1 latches a, b, c (and sub) into internal registers.
  - Clears idx and data_ready, then goes to MULT.
- MULT:
  - mul_en=1, with core inputs b_q[idx] and c_q[idx].
  - On multiplier data_ready, the product is captured into prod_q; with subtract, prod_q[63] is inverted at capture.
  - mul_en drops, then go to ADD.
- ADD:
  - add_en=1, with adder dataa=prod_q and datab=a_q[idx].
  - On adder data_ready, the adder result is written to result slot idx, add_en drops, then go to NEXT.
- NEXT (one cycle):
  - Both enables are low, so both cores are held in reset.
  - If idx==CHANNELS-1 go to DONE; else idx++ and go to MULT.
- DONE (one cycle): done=1, data_ready<=1, then go to IDLE.
- Core resets are driven as (~en | reset). Every operation therefore starts from a cleared core.
- Inputs are latched, so a, b, c may change freely after the accepting cycle.
- result holds its last value until overwritten slot-by-slot by the next request.
- Boundary conditions:
  - start outside IDLE (including during DONE) is ignored; there is no queueing.
  - reset at any point returns the FSM to IDLE with idx=0 and all outputs cleared; both cores are held in reset that cycle.
  - CHANNELS=1: NEXT goes straight to DONE.
  - NaN and Inf propagate as the cores produce them; the block does no exception handling.

## Timing
- Reset values: busy=0, done=0, data_ready=0, result=0, state=IDLE, idx=0.
- Lm = cycles from mul_en rising to multiplier data_ready; La is the same for the adder.
- Per-channel cost: Lm + La + 3 cycles (MULT entry, ADD entry, NEXT).
- Total latency: done is high exactly 1 + CHANNELS*(Lm+La+3) cycles after the start-accept edge.
- busy falls in the cycle after done.
- A new start is accepted in the first IDLE cycle after DONE. Back-to-back requests therefore have one cycle of gap.
- Each result slot updates on the edge where the adder data_ready is seen and is stable from then on.

## Configuration
- FP_MAC_SUB_EN defined:
  - The sub port exists and is latched at start.
  - Channels with sub[i]=1 compute a[i] - b[i]*c[i] by inverting the product sign bit.
- FP_MAC_SUB_EN undefined:
  - The sub port and its register are absent.
  - All channels compute a + b*c; the netlist has no sign-inversion logic.

## Structure
- Shared package fp_mac_pkg holds:
  - typedef enum logic [2:0] fp_mac_state_t {IDLE, MULT, ADD, NEXT, DONE};
  - localparam DW = 64;
  - the double constants used by benches (FP_ZERO, FP_HALF, FP_ONE, FP_TWO, FP_THREE, FP_SEVEN).
- One sub-module, fp_mul_add_core, contains:
  - `DoubleMultiply`, `DoubleAdder`, prod_q and the optional sign inversion;
  - ports mul_en, add_en, the operands, mul_done, add_done and sum.
- fp_mul_add_seq holds the FSM, the input registers, the index and the result registers.

## Test plan
- CHANNELS=2:
  - Stimulus: ch0 a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0), c=0x3FE0000000000000 (0.5); ch1 a=1.0, b=2.0, c=0x4008000000000000 (3.0); pulse start.
  - Response: ch0=0x4000000000000000 and ch1=0x401C000000000000; done pulses once at 1+2*(Lm+La+3) cycles after start; data_ready stays high.
- FP_MAC_SUB_EN, ch0 sub=1 with a=1.0, b=2.0, c=0.5 -> result ch0 = 0x0000000000000000 (+0.0); ch1 with sub=0 unchanged at 7.0.
- start re-pulsed during MULT with different operands -> ignored; results match the first operand set; exactly one done pulse.
- reset asserted for one cycle during ADD of ch1:
  - busy, done, data_ready and result all read 0 on the next cycle; state is IDLE.
  - A subsequent start completes normally.
- CHANNELS=1 with a=1.0, b=2.0, c=3.0 -> result 7.0; NEXT goes directly to DONE; latency 1+Lm+La+3.
- Back-to-back requests with start held high continuously -> second request accepted on the first IDLE cycle after DONE; data_ready drops there and rises again with the second done.
